// File: rtl/mips_host_pkg.sv
// Shared types and fault codes for the mips memory/loader host.
package mips_host_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [2:0] FC_NONE   = 3'd0;
   localparam logic [2:0] FC_OVF    = 3'd1;
   localparam logic [2:0] FC_DALIGN = 3'd2;
   localparam logic [2:0] FC_DRANGE = 3'd3;
   localparam logic [2:0] FC_IRANGE = 3'd4;

   // Fetch faults outrank store faults; misalignment outranks range.
   function automatic logic [2:0] fault_cause(input logic i_bad,
                                              input logic d_align,
                                              input logic d_range);
      if (i_bad) begin
         return FC_IRANGE;
      end else if (d_align) begin
         return FC_DALIGN;
      end else if (d_range) begin
         return FC_DRANGE;
      end else begin
         return FC_NONE;
      end
   endfunction

endpackage

// File: rtl/mips_word_ram.sv
// Word-wide RAM: synchronous write, asynchronous read, contents not reset.
module mips_word_ram
   import mips_host_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  word_t                    wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output word_t                    rdata
);

   word_t mem [DEPTH];

   // Single write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mips_mem_host.sv
// Program loader plus instruction/data memory host for the single-cycle mips core.
module mips_mem_host
   import mips_host_pkg::*;
#(
   parameter int IMEM_DEPTH = 64,
   parameter int DMEM_DEPTH = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [31:0] load_data,
   input  logic        load_last,
   output logic        cpu_reset,
   input  logic [31:0] pc,
   output logic [31:0] instr,
   input  logic        memWrite,
   input  logic [31:0] aluout,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        err,
   output logic [2:0]  fault_code,
   output logic [31:0] run_cycles
);

   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);
   localparam logic [IAW-1:0] WPTR_LAST = IAW'(IMEM_DEPTH - 1);

   state_t         state_r;
   logic [IAW-1:0] wptr_r;
   logic           load_ready_r;
   logic           cpu_reset_r;
   logic           err_r;
   logic [2:0]     fault_code_r;
   word_t          run_cycles_r;

   word_t      pc_word_s;
   word_t      alu_word_s;
   word_t      imem_rdata_s;
   word_t      dmem_rdata_s;
   logic       accept_s;
   logic       i_bad_s;
   logic       d_align_s;
   logic       d_oob_s;
   logic       d_range_s;
   logic [2:0] cause_s;
   logic       fault_s;
   logic       store_s;

   assign pc_word_s  = pc >> 2;
   assign alu_word_s = aluout >> 2;

   mips_word_ram #(.DEPTH(IMEM_DEPTH)) u_imem (
      .clk   (clk),
      .we    (accept_s),
      .waddr (wptr_r),
      .wdata (load_data),
      .raddr (pc[IAW+1:2]),
      .rdata (imem_rdata_s)
   );

   mips_word_ram #(.DEPTH(DMEM_DEPTH)) u_dmem (
      .clk   (clk),
      .we    (store_s),
      .waddr (aluout[DAW+1:2]),
      .wdata (writeData),
      .raddr (aluout[DAW+1:2]),
      .rdata (dmem_rdata_s)
   );

   // Classify this cycle's core access; a faulting store never reaches dmem.
   always_comb begin
      i_bad_s   = (pc[1:0] != 2'b00) || (pc_word_s >= word_t'(IMEM_DEPTH));
      d_align_s = memWrite && (aluout[1:0] != 2'b00);
      d_oob_s   = (alu_word_s >= word_t'(DMEM_DEPTH));
      d_range_s = memWrite && d_oob_s;
      cause_s   = fault_cause(i_bad_s, d_align_s, d_range_s);
      fault_s   = (state_r == RUN) && (cause_s != FC_NONE);
      store_s   = (state_r == RUN) && memWrite && (cause_s == FC_NONE);
      accept_s  = load_valid && load_ready_r;
   end

   // Memory read paths are visible to the core only while it runs.
   always_comb begin
      if ((state_r == RUN) && (pc_word_s < word_t'(IMEM_DEPTH))) begin
         instr = imem_rdata_s;
      end else begin
         instr = 32'd0;
      end
      if ((state_r == RUN) && !d_oob_s) begin
         readData = dmem_rdata_s;
      end else begin
         readData = 32'd0;
      end
   end

   // Load/run/fault sequencing, write pointer and run-cycle counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= LOAD;
         wptr_r       <= '0;
         load_ready_r <= 1'b1;
         cpu_reset_r  <= 1'b0;
         err_r        <= 1'b0;
         fault_code_r <= FC_NONE;
         run_cycles_r <= 32'd0;
      end else begin
         case (state_r)
            LOAD: begin
               if (accept_s) begin
                  wptr_r <= wptr_r + IAW'(1);
                  if (load_last) begin
                     state_r      <= RUN;
                     load_ready_r <= 1'b0;
                     cpu_reset_r  <= 1'b1;
                  end else if (wptr_r == WPTR_LAST) begin
                     state_r      <= FAULT;
                     load_ready_r <= 1'b0;
                     err_r        <= 1'b1;
                     fault_code_r <= FC_OVF;
                  end
               end
            end
            RUN: begin
               if (run_cycles_r != 32'hFFFF_FFFF) begin
                  run_cycles_r <= run_cycles_r + 32'd1;
               end
               if (fault_s) begin
                  state_r      <= FAULT;
                  cpu_reset_r  <= 1'b0;
                  err_r        <= 1'b1;
                  fault_code_r <= cause_s;
               end
            end
            FAULT: begin
               state_r <= FAULT;
            end
            default: begin
               state_r      <= FAULT;
               load_ready_r <= 1'b0;
               cpu_reset_r  <= 1'b0;
               err_r        <= 1'b1;
            end
         endcase
      end
   end

   assign load_ready = load_ready_r;
   assign cpu_reset  = cpu_reset_r;
   assign err        = err_r;
   assign fault_code = fault_code_r;
   assign run_cycles = run_cycles_r;

endmodule

// File: tb/tb_mips_mem_host.sv
// Bench for mips_mem_host: directed tables plus random core traffic against a memory model.
module tb_mips_mem_host;
   import mips_host_pkg::*;

   localparam int    ID  = 64;
   localparam int    DD  = 64;
   localparam word_t IDW = 32'd64;
   localparam word_t DDW = 32'd64;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] load_data;
   logic        load_last;
   logic        cpu_reset;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        memWrite;
   logic [31:0] aluout;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        err;
   logic [2:0]  fault_code;
   logic [31:0] run_cycles;

   mips_mem_host #(.IMEM_DEPTH(ID), .DMEM_DEPTH(DD)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_last  (load_last),
      .cpu_reset  (cpu_reset),
      .pc         (pc),
      .instr      (instr),
      .memWrite   (memWrite),
      .aluout     (aluout),
      .writeData  (writeData),
      .readData   (readData),
      .err        (err),
      .fault_code (fault_code),
      .run_cycles (run_cycles)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: memory images plus what the host should be doing.
   word_t       im [ID];
   bit          iv [ID];
   word_t       dm [DD];
   bit          dv [DD];
   bit          loading;
   bit          running;
   logic [31:0] fc;
   logic [31:0] run_count;
   logic [5:0]  wp;

   typedef struct {
      word_t       pc;
      bit          mw;
      word_t       a;
      word_t       wd;
      word_t       ei;
      logic [31:0] efc;
   } vec_t;
   vec_t tab[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      load_valid = 1'b0;
      load_last = 1'b0;
      #1;
      loading = 1'b1;
      running = 1'b0;
      fc = 32'd0;
      run_count = 32'd0;
      wp = 6'd0;
      chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
      chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_fault_code", {29'd0, fault_code}, 32'd0);
      chk("rst_run_cycles", run_cycles, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_readData", readData, 32'd0);
      #3;
      reset = 1'b1;
   endtask

   task automatic load_words(input word_t w[$], input bit with_last, input bit gaps);
      for (int i = 0; i < w.size(); i++) begin
         if (gaps) begin
            @(negedge clk);
            load_valid = 1'b0;
            load_data = 32'hDEAD_BEEF;
            load_last = 1'b1;
         end
         @(negedge clk);
         load_valid = 1'b1;
         load_data = w[i];
         load_last = with_last && (i == w.size() - 1);
         #1;
         chk("load_ready", {31'd0, load_ready}, {31'd0, loading});
         chk("load_instr", instr, 32'd0);
         chk("load_readData", readData, 32'd0);
         @(posedge clk);
         if (loading) begin
            im[wp] = w[i];
            iv[wp] = 1'b1;
            if (load_last) begin
               loading = 1'b0;
               running = 1'b1;
            end else if (wp == 6'd63) begin
               loading = 1'b0;
               fc = 32'd1;
            end
            wp = wp + 6'd1;
         end
         #1;
         chk("load_cpu_reset", {31'd0, cpu_reset}, {31'd0, running});
         chk("load_err", {31'd0, err}, {31'd0, fc != 32'd0});
         chk("load_fault_code", {29'd0, fault_code}, fc);
         chk("load_ready_after", {31'd0, load_ready}, {31'd0, loading});
      end
   endtask

   task automatic core_cycle(input word_t p, input bit mw, input word_t a, input word_t wd,
                             input bit use_tab, input word_t t_instr, input logic [31:0] t_fc);
      logic [31:0] code;
      @(negedge clk);
      pc = p;
      memWrite = mw;
      aluout = a;
      writeData = wd;
      load_valid = 1'($urandom_range(0, 1));
      load_data = $urandom;
      load_last = 1'($urandom_range(0, 1));
      #1;
      code = 32'd0;
      if (running) begin
         if ((p % 32'd4 != 32'd0) || (p / 32'd4 >= IDW)) code = 32'd4;
         else if (mw && (a % 32'd4 != 32'd0)) code = 32'd2;
         else if (mw && (a / 32'd4 >= DDW)) code = 32'd3;
         if ((p / 32'd4 < IDW) && iv[p[7:2]]) chk("instr", instr, im[p[7:2]]);
         if (a / 32'd4 >= DDW) chk("readData_oob", readData, 32'd0);
         else if (dv[a[7:2]]) chk("readData", readData, dm[a[7:2]]);
      end else begin
         chk("idle_instr", instr, 32'd0);
         chk("idle_readData", readData, 32'd0);
      end
      if (use_tab) chk("tab_instr", instr, t_instr);
      @(posedge clk);
      if (running) begin
         if (run_count != 32'hFFFF_FFFF) run_count = run_count + 32'd1;
         if (code != 32'd0) begin
            running = 1'b0;
            fc = code;
         end else if (mw) begin
            dm[a[7:2]] = wd;
            dv[a[7:2]] = 1'b1;
         end
      end
      #1;
      chk("err", {31'd0, err}, {31'd0, fc != 32'd0});
      chk("fault_code", {29'd0, fault_code}, fc);
      chk("cpu_reset", {31'd0, cpu_reset}, {31'd0, running});
      chk("load_ready_run", {31'd0, load_ready}, 32'd0);
      chk("run_cycles", run_cycles, run_count);
      if (use_tab) chk("tab_fault_code", {29'd0, fault_code}, t_fc);
   endtask

   task automatic add_vec(input word_t p, input bit mw, input word_t a, input word_t wd,
                          input word_t ei, input logic [31:0] efc);
      vec_t v;
      v.pc = p; v.mw = mw; v.a = a; v.wd = wd; v.ei = ei; v.efc = efc;
      tab.push_back(v);
   endtask

   task automatic run_tab();
      for (int i = 0; i < tab.size(); i++) begin
         core_cycle(tab[i].pc, tab[i].mw, tab[i].a, tab[i].wd, 1'b1, tab[i].ei, tab[i].efc);
      end
      tab.delete();
   endtask

   task automatic plain_cycle(input word_t p, input bit mw, input word_t a, input word_t wd);
      core_cycle(p, mw, a, wd, 1'b0, 32'd0, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

   initial begin
      word_t       prog[$];
      logic [31:0] rc_hold;
      int          r;
      word_t       p;
      word_t       a;
      word_t       wd;
      bit          mw;

      reset = 1'b0;
      load_valid = 1'b0;
      load_data = 32'd0;
      load_last = 1'b0;
      pc = 32'd0;
      memWrite = 1'b0;
      aluout = 32'd0;
      writeData = 32'd0;
      for (int i = 0; i < ID; i++) iv[i] = 1'b0;
      for (int i = 0; i < DD; i++) dv[i] = 1'b0;

      // 13-word program; the store to 6(R1) is misaligned.
      apply_reset();
      prog = '{32'h2022_0008, 32'h0022_1822, 32'h0062_2025, 32'h8C25_0004, 32'hAC25_0006,
               32'h0065_302A, 32'h00C5_3820, 32'h10E0_0002, 32'h00E2_4020, 32'h0103_4822,
               32'h0800_0000, 32'h0000_0000, 32'h0000_0000};
      load_words(prog, 1'b1, 1'b0);
      add_vec(32'd0,  1'b0, 32'd0, 32'd0,      32'h2022_0008, 32'd0);
      add_vec(32'd4,  1'b0, 32'd0, 32'd0,      32'h0022_1822, 32'd0);
      add_vec(32'd8,  1'b0, 32'd0, 32'd0,      32'h0062_2025, 32'd0);
      add_vec(32'd16, 1'b1, 32'd6, 32'h1234,   32'hAC25_0006, 32'd2);
      add_vec(32'd20, 1'b0, 32'd0, 32'd0,      32'd0,         32'd2);
      add_vec(32'd24, 1'b1, 32'd8, 32'h5555,   32'd0,         32'd2);
      run_tab();

      // addi/sw/lw round trip, then a same-cycle read and write of that word.
      apply_reset();
      prog = '{32'h2001_0023, 32'hAC01_0008, 32'h8C02_0008};
      load_words(prog, 1'b1, 1'b0);
      add_vec(32'd0, 1'b0, 32'd0, 32'd0,  32'h2001_0023, 32'd0);
      add_vec(32'd4, 1'b1, 32'd8, 32'd35, 32'hAC01_0008, 32'd0);
      add_vec(32'd8, 1'b0, 32'd8, 32'd0,  32'h8C02_0008, 32'd0);
      add_vec(32'd0, 1'b1, 32'd8, 32'd99, 32'h2001_0023, 32'd0);
      add_vec(32'd8, 1'b0, 32'd8, 32'd0,  32'h8C02_0008, 32'd0);
      run_tab();

      // Loader backpressure: valid toggles every other cycle.
      apply_reset();
      prog = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
      load_words(prog, 1'b1, 1'b1);
      add_vec(32'd0,  1'b0, 32'd0, 32'd0, 32'h1111_0001, 32'd0);
      add_vec(32'd4,  1'b0, 32'd0, 32'd0, 32'h2222_0002, 32'd0);
      add_vec(32'd8,  1'b0, 32'd0, 32'd0, 32'h3333_0003, 32'd0);
      add_vec(32'd12, 1'b0, 32'd0, 32'd0, 32'h4444_0004, 32'd0);
      run_tab();

      // Full imem without a last marker overflows.
      apply_reset();
      prog.delete();
      for (int i = 0; i < ID; i++) prog.push_back($urandom);
      load_words(prog, 1'b0, 1'b0);
      add_vec(32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd1);
      add_vec(32'd4, 1'b1, 32'd4, 32'd7, 32'd0, 32'd1);
      run_tab();

      // One-word program, out-of-range store, dmem survives into a reload.
      apply_reset();
      prog = '{32'h2001_0023};
      load_words(prog, 1'b1, 1'b0);
      plain_cycle(32'd0, 1'b1, 32'd0, 32'hA5A5_0000);
      plain_cycle(32'd0, 1'b1, 32'd8, 32'h0000_0055);
      add_vec(32'd0, 1'b1, 32'd256, 32'h0000_0BAD, 32'h2001_0023, 32'd3);
      add_vec(32'd0, 1'b0, 32'd0,   32'd0,         32'd0,         32'd3);
      run_tab();
      rc_hold = run_cycles;
      plain_cycle(32'd0, 1'b0, 32'd0, 32'd0);
      chk("run_cycles_frozen", run_cycles, rc_hold);
      apply_reset();
      load_words(prog, 1'b1, 1'b0);
      plain_cycle(32'd0, 1'b0, 32'd0, 32'd0);
      plain_cycle(32'd0, 1'b0, 32'd8, 32'd0);

      // Reset pulse while running, then restart with a one-word program.
      plain_cycle(32'd0, 1'b0, 32'd4, 32'd0);
      apply_reset();
      prog = '{32'h0000_0000};
      load_words(prog, 1'b1, 1'b0);
      plain_cycle(32'd0, 1'b0, 32'd0, 32'd0);
      chk("restart_run_cycles", run_cycles, 32'd1);

      // Random core traffic with occasional faults; reload after each fault.
      apply_reset();
      prog.delete();
      for (int i = 0; i < 32; i++) prog.push_back($urandom);
      load_words(prog, 1'b1, 1'b0);
      for (int n = 0; n < 400; n++) begin
         if (!running) begin
            apply_reset();
            prog.delete();
            for (int i = 0; i < 32; i++) prog.push_back($urandom);
            load_words(prog, 1'b1, 1'($urandom_range(0, 1)));
         end
         r  = int'($urandom_range(0, 59));
         p  = 32'd4 * $urandom_range(0, 31);
         a  = 32'd4 * $urandom_range(0, 63);
         mw = 1'($urandom_range(0, 1));
         wd = $urandom;
         case (r)
            0: p = p + $urandom_range(1, 3);
            1: p = 32'd4 * $urandom_range(64, 5000);
            2: begin mw = 1'b1; a = a + $urandom_range(1, 3); end
            3: begin mw = 1'b1; a = 32'd4 * $urandom_range(64, 5000); end
            4: begin mw = 1'b0; a = 32'd4 * $urandom_range(64, 5000); end
            default: ;
         endcase
         plain_cycle(p, mw, a, wd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
